nfsr_keystream: RTL and testbench



---
 rtl/nfsr_keystream_pkg.sv | 18 +
 rtl/nfsr_keystream_if.sv | 25 ++
 rtl/nfsr_keystream_core.sv | 30 +++
 rtl/nfsr_keystream.sv | 144 ++++++++++++++
 tb/tb_nfsr_keystream.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/nfsr_keystream_pkg.sv
// Shared types and default tap masks for the NFSR keystream generator.
package nfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WARM = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int unsigned NUM_NL = 4;

    localparam logic [23:0] DEF_LIN_MASK = 24'h420261;
    localparam logic [23:0] DEF_NL_MASK0 = 24'h002010;
    localparam logic [23:0] DEF_NL_MASK1 = 24'h010100;
    localparam logic [23:0] DEF_NL_MASK2 = 24'h004820;
    localparam logic [23:0] DEF_NL_MASK3 = 24'h000524;

endpackage

// File: rtl/nfsr_keystream_if.sv
// Control, status and output-word handshake signals of the keystream generator.
interface nfsr_keystream_if #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned OUT_W = 8
);
    logic             seed_valid;
    logic [WIDTH-1:0] seed;
    logic             stop;
    logic             seed_err;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [WIDTH-1:0] state_out;

    modport master (
        output seed_valid, seed, stop, out_ready,
        input  seed_err, busy, out_valid, out_data, state_out
    );

    modport slave (
        input  seed_valid, seed, stop, out_ready,
        output seed_err, busy, out_valid, out_data, state_out
    );
endinterface

// File: rtl/nfsr_keystream_core.sv
// Combinational NFSR step: linear taps plus AND-terms, shifted in at the MSB.
module nfsr_core
    import nfsr_pkg::*;
#(
    parameter int unsigned      WIDTH    = 24,
    parameter logic [WIDTH-1:0] LIN_MASK = WIDTH'(DEF_LIN_MASK),
    parameter logic [WIDTH-1:0] NL_MASK0 = WIDTH'(DEF_NL_MASK0),
    parameter logic [WIDTH-1:0] NL_MASK1 = WIDTH'(DEF_NL_MASK1),
    parameter logic [WIDTH-1:0] NL_MASK2 = WIDTH'(DEF_NL_MASK2),
    parameter logic [WIDTH-1:0] NL_MASK3 = WIDTH'(DEF_NL_MASK3)
) (
    input  logic [WIDTH-1:0] state,
    output logic             fb,
    output logic [WIDTH-1:0] state_next
);

    localparam logic [WIDTH-1:0] NL_MASKS [NUM_NL] = '{NL_MASK0, NL_MASK1, NL_MASK2, NL_MASK3};

    always_comb begin
        fb = ^(state & LIN_MASK);
        // An all-zero mask would reduce to constant 1, so it is skipped.
        for (int unsigned k = 0; k < NUM_NL; k++) begin
            if (NL_MASKS[k] != '0) begin
                fb = fb ^ (&(state | ~NL_MASKS[k]));
            end
        end
        state_next = {fb, state[WIDTH-1:1]};
    end

endmodule

// File: rtl/nfsr_keystream.sv
// NFSR keystream generator: seeding with zero guard, warm-up discard, packed
// output words with valid/ready backpressure.
module nfsr_keystream
    import nfsr_pkg::*;
#(
    parameter int unsigned      WIDTH    = 24,
    parameter logic [WIDTH-1:0] LIN_MASK = WIDTH'(DEF_LIN_MASK),
    parameter logic [WIDTH-1:0] NL_MASK0 = WIDTH'(DEF_NL_MASK0),
    parameter logic [WIDTH-1:0] NL_MASK1 = WIDTH'(DEF_NL_MASK1),
    parameter logic [WIDTH-1:0] NL_MASK2 = WIDTH'(DEF_NL_MASK2),
    parameter logic [WIDTH-1:0] NL_MASK3 = WIDTH'(DEF_NL_MASK3),
    parameter int unsigned      WARMUP   = 32,
    parameter int unsigned      OUT_W    = 8
) (
    input logic             clk,
    input logic             rst,
    nfsr_keystream_if.slave bus
);

    localparam int unsigned       CNT_W     = $clog2(OUT_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(OUT_W - 1);
    localparam logic [31:0]       WARM_LAST = 32'(WARMUP - 1);

    state_t             fsm_q, fsm_d;
    logic [WIDTH-1:0]   reg_q, reg_d;
    logic [31:0]        warm_q, warm_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   coll_q, coll_d;
    logic [OUT_W-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               seed_err_q, seed_err_d;

    logic [WIDTH-1:0]   core_next;
    logic               fb_unused;
    logic [OUT_W-1:0]   coll_shift;

    nfsr_core #(
        .WIDTH   (WIDTH),
        .LIN_MASK(LIN_MASK),
        .NL_MASK0(NL_MASK0),
        .NL_MASK1(NL_MASK1),
        .NL_MASK2(NL_MASK2),
        .NL_MASK3(NL_MASK3)
    ) u_core (
        .state     (reg_q),
        .fb        (fb_unused),
        .state_next(core_next)
    );

    always_comb begin
        coll_shift = coll_q >> 1;
        coll_shift[OUT_W-1] = reg_q[0];
    end

    always_comb begin
        fsm_d      = fsm_q;
        reg_d      = reg_q;
        warm_d     = warm_q;
        cnt_d      = cnt_q;
        coll_d     = coll_q;
        data_d     = data_q;
        valid_d    = valid_q;
        seed_err_d = 1'b0;

        // A rejected zero seed still outranks stop and freezes the block for that cycle.
        if (bus.seed_valid) begin
            if (bus.seed == '0) begin
                seed_err_d = 1'b1;
            end else begin
                reg_d   = bus.seed;
                warm_d  = '0;
                cnt_d   = '0;
                valid_d = 1'b0;
                fsm_d   = (WARMUP == 0) ? RUN : WARM;
            end
        end else if (bus.stop) begin
            fsm_d   = IDLE;
            valid_d = 1'b0;
        end else begin
            case (fsm_q)
                WARM: begin
                    reg_d = core_next;
                    if (warm_q == WARM_LAST) begin
                        fsm_d = RUN;
                    end else begin
                        warm_d = warm_q + 32'd1;
                    end
                end
                RUN: begin
                    if (valid_q && bus.out_ready) begin
                        valid_d = 1'b0;
                    end
                    // Only the word-completing step can collide with an unaccepted word.
                    if (!(cnt_q == CNT_LAST && valid_q && !bus.out_ready)) begin
                        reg_d  = core_next;
                        coll_d = coll_shift;
                        if (cnt_q == CNT_LAST) begin
                            data_d  = coll_shift;
                            valid_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        busy_d = (fsm_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q      <= IDLE;
            reg_q      <= '0;
            warm_q     <= '0;
            cnt_q      <= '0;
            coll_q     <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            seed_err_q <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            reg_q      <= reg_d;
            warm_q     <= warm_d;
            cnt_q      <= cnt_d;
            coll_q     <= coll_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            seed_err_q <= seed_err_d;
        end
    end

    assign bus.seed_err  = seed_err_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.state_out = reg_q;

endmodule

// File: tb/tb_nfsr_keystream.sv
// Directed bench for nfsr_keystream: one instance without warm-up, one with 32 steps.
module tb_nfsr_keystream;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    nfsr_keystream_if #(.WIDTH(24), .OUT_W(8)) if0 ();
    nfsr_keystream_if #(.WIDTH(24), .OUT_W(8)) if32 ();

    nfsr_keystream #(.WARMUP(0), .OUT_W(8)) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(if0)
    );

    nfsr_keystream #(.WARMUP(32), .OUT_W(8)) dut32 (
        .clk(clk),
        .rst(rst),
        .bus(if32)
    );

    function automatic logic [23:0] mstep(input logic [23:0] s);
        logic f;
        f = s[0] ^ s[5] ^ s[6] ^ s[9] ^ s[17] ^ s[22]
          ^ (s[4] & s[13])
          ^ (s[8] & s[16])
          ^ (s[5] & s[11] & s[14])
          ^ (s[2] & s[5] & s[8] & s[10]);
        return {f, s[23:1]};
    endfunction

    function automatic logic [23:0] state_after(input logic [23:0] seed, input int n);
        logic [23:0] s;
        s = seed;
        for (int i = 0; i < n; i++) s = mstep(s);
        return s;
    endfunction

    function automatic logic [7:0] word_at(input logic [23:0] seed, input int n);
        logic [23:0] s;
        logic [7:0]  w;
        s = state_after(seed, 8 * n);
        for (int i = 0; i < 8; i++) begin
            w[i] = s[0];
            s = mstep(s);
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [23:0] exp_seq [8];
    logic [23:0] held;
    int          cycles;

    initial begin
        exp_seq = '{24'h800000, 24'h400000, 24'hA00000, 24'h500000,
                    24'hA80000, 24'h540000, 24'hAA0000, 24'hD50000};
        if0.seed_valid = 1'b0;  if0.seed = '0;  if0.stop = 1'b0;  if0.out_ready = 1'b1;
        if32.seed_valid = 1'b0; if32.seed = '0; if32.stop = 1'b0; if32.out_ready = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_state", 32'(if0.state_out), 32'h0);
        chk("rst_data", 32'(if0.out_data), 32'h0);
        chk("rst_valid", 32'(if0.out_valid), 32'h0);
        chk("rst_busy", 32'(if0.busy), 32'h0);
        chk("rst_seed_err", 32'(if0.seed_err), 32'h0);
        chk("rst_busy32", 32'(if32.busy), 32'h0);
        rst = 1'b1;
        tick();

        // Zero seed in IDLE
        if0.seed_valid = 1'b1; if0.seed = 24'h0;
        tick();
        if0.seed_valid = 1'b0;
        chk("idle_zero_err", 32'(if0.seed_err), 32'h1);
        chk("idle_zero_busy", 32'(if0.busy), 32'h0);
        chk("idle_zero_state", 32'(if0.state_out), 32'h0);
        tick();
        chk("idle_zero_err_fall", 32'(if0.seed_err), 32'h0);
        chk("idle_no_step", 32'(if0.state_out), 32'h0);

        // Seed 000001 with WARMUP=0
        if0.seed_valid = 1'b1; if0.seed = 24'h000001;
        tick();
        if0.seed_valid = 1'b0;
        chk("seed_load", 32'(if0.state_out), 32'h000001);
        chk("seed_busy", 32'(if0.busy), 32'h1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("seq%0d", i), 32'(if0.state_out), 32'(exp_seq[i]));
            if (i == 6) chk("valid_before_word", 32'(if0.out_valid), 32'h0);
        end
        chk("word0_valid", 32'(if0.out_valid), 32'h1);
        chk("word0_data", 32'(if0.out_data), 32'h01);

        // Backpressure: 20 cycles without ready
        if0.out_ready = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("stall_valid", 32'(if0.out_valid), 32'h1);
        chk("stall_data", 32'(if0.out_data), 32'h01);
        chk("stall_state", 32'(if0.state_out), 32'(state_after(24'h000001, 15)));
        if0.out_ready = 1'b1;
        tick();
        chk("resume_valid", 32'(if0.out_valid), 32'h1);
        chk("resume_word1", 32'(if0.out_data), 32'(word_at(24'h000001, 1)));
        chk("resume_state", 32'(if0.state_out), 32'(state_after(24'h000001, 16)));
        tick();
        chk("word1_taken", 32'(if0.out_valid), 32'h0);
        for (int i = 0; i < 7; i++) tick();
        chk("word2_valid", 32'(if0.out_valid), 32'h1);
        chk("word2_data", 32'(if0.out_data), 32'(word_at(24'h000001, 2)));
        chk("word2_state", 32'(if0.state_out), 32'(state_after(24'h000001, 24)));

        // Zero seed while running
        held = if0.state_out;
        if0.seed_valid = 1'b1; if0.seed = 24'h0;
        tick();
        if0.seed_valid = 1'b0;
        chk("run_zero_err", 32'(if0.seed_err), 32'h1);
        chk("run_zero_state", 32'(if0.state_out), 32'(held));
        chk("run_zero_valid", 32'(if0.out_valid), 32'h1);
        chk("run_zero_busy", 32'(if0.busy), 32'h1);

        // stop and reseed in the same cycle: reseed wins
        if0.seed_valid = 1'b1; if0.seed = 24'hABCDEF; if0.stop = 1'b1;
        tick();
        if0.seed_valid = 1'b0; if0.stop = 1'b0;
        chk("reseed_state", 32'(if0.state_out), 32'hABCDEF);
        chk("reseed_valid", 32'(if0.out_valid), 32'h0);
        chk("reseed_busy", 32'(if0.busy), 32'h1);
        for (int i = 0; i < 7; i++) tick();
        chk("reseed_no_early", 32'(if0.out_valid), 32'h0);
        tick();
        chk("reseed_valid8", 32'(if0.out_valid), 32'h1);
        chk("reseed_word0", 32'(if0.out_data), 32'(word_at(24'hABCDEF, 0)));

        // stop alone
        held = if0.state_out;
        if0.stop = 1'b1;
        tick();
        if0.stop = 1'b0;
        chk("stop_busy", 32'(if0.busy), 32'h0);
        chk("stop_valid", 32'(if0.out_valid), 32'h0);
        chk("stop_state", 32'(if0.state_out), 32'(held));
        tick(); tick(); tick();
        chk("stop_hold", 32'(if0.state_out), 32'(held));

        // WARMUP=32: first word 40 cycles after acceptance
        if32.seed_valid = 1'b1; if32.seed = 24'h000001;
        tick();
        if32.seed_valid = 1'b0;
        chk("w32_busy", 32'(if32.busy), 32'h1);
        cycles = 0;
        while (!if32.out_valid && cycles < 100) begin
            tick();
            cycles++;
        end
        chk("w32_latency", 32'(cycles), 32'd40);
        chk("w32_word", 32'(if32.out_data), 32'(word_at(24'h000001, 4)));

        // Reseed mid-run restarts warm-up
        if32.seed_valid = 1'b1; if32.seed = 24'h5A5A5A;
        tick();
        if32.seed_valid = 1'b0;
        chk("w32_reseed_valid", 32'(if32.out_valid), 32'h0);
        chk("w32_reseed_state", 32'(if32.state_out), 32'h5A5A5A);
        cycles = 0;
        while (!if32.out_valid && cycles < 100) begin
            tick();
            cycles++;
        end
        chk("w32_relatency", 32'(cycles), 32'd40);
        chk("w32_reword", 32'(if32.out_data), 32'(word_at(24'h5A5A5A, 4)));

        // Async reset mid-word
        if0.seed_valid = 1'b1; if0.seed = 24'h123456;
        tick();
        if0.seed_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        chk("arst_state", 32'(if0.state_out), 32'h0);
        chk("arst_data", 32'(if0.out_data), 32'h0);
        chk("arst_valid", 32'(if0.out_valid), 32'h0);
        chk("arst_busy", 32'(if0.busy), 32'h0);
        chk("arst_state32", 32'(if32.state_out), 32'h0);
        tick(); tick();
        rst = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_state", 32'(if0.state_out), 32'h0);
        chk("post_rst_busy", 32'(if0.busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
